hex_history_display: RTL



---
 rtl/hex_history_display.sv | 106 ++++++++++
 1 files changed

// File: rtl/hex_history_display.sv
// hex_history_display
//   Display stage for a 4-bit counter. Each load strobe pushes `value` into a
//   4-deep history. A 4-digit, common-anode, time-multiplexed 7-segment display
//   shows the newest sample on digit 0 and the oldest on digit 3. The decimal
//   point on digit 0 lights when the counter wrapped between the two newest
//   samples. Each digit is driven for PRESCALE clock cycles in turn.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   value  in   [3:0] counter value to capture
//   load   in   capture strobe (legal on any cycle)
//   seg    out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   an     out  [3:0] digit anodes, active-low, one-hot
//   dp     out  decimal point, active-low
module hex_history_display #(
  parameter int PRESCALE = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] value,
  input  logic       load,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCW-1:0] PC_LAST = PCW'(PRESCALE - 1);

  logic [3:0]     h [4];
  logic [3:0]     v;
  logic [PCW-1:0] pc;
  logic [1:0]     idx;
  logic           tick;

  logic [6:0] seg_nxt;
  logic [3:0] an_nxt;
  logic       dp_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tick = (pc == PC_LAST);

  // Outputs are computed from the pre-edge scan index and history, so a load
  // or index advance shows up one cycle later.
  always_comb begin
    seg_nxt = 7'b1111111;
    an_nxt  = ~(4'b0001 << idx);
    dp_nxt  = 1'b1;
    if (v[idx]) seg_nxt = hex7(h[idx]);
    // A newer sample smaller than the previous one means the counter wrapped.
    if (idx == 2'd0 && v[0] && v[1] && (h[0] < h[1])) dp_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) h[i] <= 4'h0;
      v   <= 4'b0000;
      pc  <= '0;
      idx <= 2'd0;
      seg <= 7'b1111111;
      an  <= 4'b1111;
      dp  <= 1'b1;
    end else begin
      if (load) begin
        h[0] <= value;
        h[1] <= h[0];
        h[2] <= h[1];
        h[3] <= h[2];
        v    <= {v[2:0], 1'b1};
      end
      if (tick) begin
        pc  <= '0;
        idx <= idx + 2'd1;
      end else begin
        pc  <= pc + 1'b1;
      end
      seg <= seg_nxt;
      an  <= an_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule
